// File: rtl/buffer_pkg.sv
// ---------------------------------------------------------------------------
// buffer_pkg
// Shared helpers for the multi-bank accumulating buffer.
//   add_sat : width-parameterised add with carry-out and optional clamp.
//             Operands travel in MAXW-bit containers; the result is
//             {carry, sum}, where sum is clamped or wrapped to w bits.
//   ptr_inc : ring-pointer increment with wrap at n.
// ---------------------------------------------------------------------------
package buffer_pkg;

   // Widest accumulator the helpers support (OWID <= MAXW).
   localparam int unsigned MAXW = 32;

   function automatic logic [MAXW:0] add_sat(input logic [MAXW-1:0] a,
                                            input logic [MAXW-1:0] b,
                                            input int unsigned     w,
                                            input logic            sat);
      logic [MAXW:0] s;
      logic [MAXW:0] m;
      logic          carry;
      s     = {1'b0, a} + {1'b0, b};
      // Operands are below 2^w, so bit w of the wide sum is the carry out.
      carry = s[w];
      m     = ({{MAXW{1'b0}}, 1'b1} << w) - (MAXW+1)'(1);
      if (carry && sat) return {1'b1, m[MAXW-1:0]};
      return {carry, s[MAXW-1:0] & m[MAXW-1:0]};
   endfunction

   function automatic int unsigned ptr_inc(input int unsigned p,
                                           input int unsigned n);
      return (p + 1 >= n) ? 0 : p + 1;
   endfunction

endpackage

// File: rtl/buffer_multi_bank_array_acc_bank.sv
// ---------------------------------------------------------------------------
// acc_bank
// One bank of DIM unsigned OWID-bit accumulators with a sticky overflow flag.
//   clk, rst_n : clock, async active-low reset
//   clr        : zero all accumulators and the overflow flag (wins over add)
//   add_en     : add inc[i] into acc[i] for every channel
//   inc        : per-channel increments (IWID bits each)
//   acc        : current accumulator contents
//   ovf        : set when any channel carried out since the last clear
// SAT != 0 clamps each channel at all-ones; SAT == 0 wraps modulo 2^OWID.
// ---------------------------------------------------------------------------
module acc_bank
   import buffer_pkg::*;
#(
   parameter int DIM  = 4,
   parameter int IWID = 1,
   parameter int OWID = 8,
   parameter int SAT  = 1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           clr,
   input  logic                           add_en,
   input  logic [DIM-1:0][IWID-1:0]       inc,
   output logic [DIM-1:0][OWID-1:0]       acc,
   output logic                           ovf
);

   logic [DIM-1:0][OWID-1:0] acc_d, acc_q;
   logic                     ovf_d, ovf_q;
   logic [MAXW:0]            sum;

   always_comb begin
      acc_d = acc_q;
      ovf_d = ovf_q;
      sum   = '0;
      if (clr) begin
         acc_d = '0;
         ovf_d = 1'b0;
      end else if (add_en) begin
         for (int i = 0; i < DIM; i++) begin
            sum      = add_sat(MAXW'(acc_q[i]), MAXW'(inc[i]), OWID, SAT != 0);
            acc_d[i] = sum[OWID-1:0];
            if (sum[MAXW]) ovf_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         ovf_q <= ovf_d;
      end
   end

   assign acc = acc_q;
   assign ovf = ovf_q;

endmodule

// File: rtl/buffer_multi_bank_array.sv
// ---------------------------------------------------------------------------
// buffer_multi_bank_array
// Ring of NBANK accumulating banks: bank wr_ptr accumulates, banks
// rd_ptr .. rd_ptr+full_cnt-1 are sealed and drained oldest-first.
//   clk, rst_n      : clock, async active-low reset
//   iValid, iData   : per-channel increments for the accumulating bank
//   iClear          : discard the accumulating bank (blocks a same-cycle swap)
//   iSwap           : seal the accumulating bank when oSwapReady
//   oSwapReady      : a free bank exists
//   oValid, iReady  : output handshake for the oldest sealed bank
//   oData, oOvf     : contents / overflow flag of the oldest sealed bank
// ---------------------------------------------------------------------------
module buffer_multi_bank_array
   import buffer_pkg::*;
#(
   parameter int DIM   = 4,
   parameter int IWID  = 1,
   parameter int OWID  = 8,
   parameter int NBANK = 2,
   parameter int SAT   = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     iValid,
   input  logic [DIM-1:0][IWID-1:0] iData,
   input  logic                     iClear,
   input  logic                     iSwap,
   output logic                     oSwapReady,
   output logic                     oValid,
   input  logic                     iReady,
   output logic [DIM-1:0][OWID-1:0] oData,
   output logic                     oOvf
);

   localparam int PW = $clog2(NBANK);

   logic [PW-1:0] wr_d, wr_q, rd_d, rd_q, cnt_d, cnt_q;
   logic          swap_ok, drain;
   logic [NBANK-1:0] bank_clr, bank_add, bank_ovf;
   logic [NBANK-1:0][DIM-1:0][OWID-1:0] bank_acc;

   // Both flags come from registers only, so there is no iSwap->oValid or
   // iReady->oSwapReady combinational path.
   assign oSwapReady = cnt_q < PW'(NBANK-1);
   assign oValid     = cnt_q != '0;
   assign swap_ok    = iSwap & oSwapReady & ~iClear;
   assign drain      = oValid & iReady;

   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (swap_ok) wr_d = PW'(ptr_inc(32'(wr_q), NBANK));
      if (drain)   rd_d = PW'(ptr_inc(32'(rd_q), NBANK));
      case ({swap_ok, drain})
         2'b10:   cnt_d = cnt_q + PW'(1);
         2'b01:   cnt_d = cnt_q - PW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // full_cnt never reaches NBANK, so the draining bank is never the
   // accumulating one and the two clear sources never collide.
   always_comb begin
      bank_clr = '0;
      bank_add = '0;
      for (int b = 0; b < NBANK; b++) begin
         bank_add[b] = iValid & ~iClear & (wr_q == PW'(b));
         bank_clr[b] = (iClear & (wr_q == PW'(b))) | (drain & (rd_q == PW'(b)));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   for (genvar b = 0; b < NBANK; b++) begin : g_bank
      acc_bank #(
         .DIM  (DIM),
         .IWID (IWID),
         .OWID (OWID),
         .SAT  (SAT)
      ) u_bank (
         .clk    (clk),
         .rst_n  (rst_n),
         .clr    (bank_clr[b]),
         .add_en (bank_add[b]),
         .inc    (iData),
         .acc    (bank_acc[b]),
         .ovf    (bank_ovf[b])
      );
   end

   assign oData = bank_acc[rd_q];
   assign oOvf  = bank_ovf[rd_q];

endmodule

// File: tb/tb_buffer_multi_bank_array.sv
// Two instances (clamping and wrapping) share one stimulus stream; a
// queue-based model predicts each sealed bank, a negedge monitor compares.
module tb_buffer_multi_bank_array;

   localparam int DIM   = 4;
   localparam int IWID  = 2;
   localparam int OWID  = 4;
   localparam int NBANK = 3;
   localparam int MAXV  = (1 << OWID) - 1;

   typedef struct packed {
      logic                 ovf;
      logic [DIM*OWID-1:0]  data;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   logic ivalid, iclear, iswap, iready;
   logic [DIM-1:0][IWID-1:0] idata;
   logic                     osr    [2];
   logic                     ovalid [2];
   logic                     oovf   [2];
   logic [DIM-1:0][OWID-1:0] odata  [2];

   int checks   = 0;
   int failures = 0;
   bit run      = 0;

   // Model state: index 0 = clamping instance, 1 = wrapping instance.
   int   m_acc [2][DIM];
   bit   m_ovf [2];
   int   m_cnt;
   exp_t q0[$];
   exp_t q1[$];

   always #5 clk = ~clk;

   buffer_multi_bank_array #(.DIM(DIM), .IWID(IWID), .OWID(OWID), .NBANK(NBANK), .SAT(1)) u_sat (
      .clk(clk), .rst_n(rst_n), .iValid(ivalid), .iData(idata), .iClear(iclear),
      .iSwap(iswap), .oSwapReady(osr[0]), .oValid(ovalid[0]), .iReady(iready),
      .oData(odata[0]), .oOvf(oovf[0]));

   buffer_multi_bank_array #(.DIM(DIM), .IWID(IWID), .OWID(OWID), .NBANK(NBANK), .SAT(0)) u_wrap (
      .clk(clk), .rst_n(rst_n), .iValid(ivalid), .iData(idata), .iClear(iclear),
      .iSwap(iswap), .oSwapReady(osr[1]), .oValid(ovalid[1]), .iReady(iready),
      .oData(odata[1]), .oOvf(oovf[1]));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_clear();
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < DIM; i++) m_acc[k][i] = 0;
         m_ovf[k] = 0;
      end
      m_cnt = 0;
      q0.delete();
      q1.delete();
   endfunction

   // Applies the inputs held across the edge that just occurred.
   function automatic void model_step();
      bit   drain, ready;
      int   s;
      exp_t e;
      drain = (m_cnt != 0) && iready;
      ready = m_cnt < NBANK - 1;
      for (int k = 0; k < 2; k++) begin
         if (iclear) begin
            for (int i = 0; i < DIM; i++) m_acc[k][i] = 0;
            m_ovf[k] = 0;
         end else begin
            if (ivalid) begin
               for (int i = 0; i < DIM; i++) begin
                  s = m_acc[k][i] + int'(idata[i]);
                  if (s > MAXV) begin
                     m_ovf[k] = 1;
                     s = (k == 0) ? MAXV : s - (MAXV + 1);
                  end
                  m_acc[k][i] = s;
               end
            end
            if (iswap && ready) begin
               e.ovf = m_ovf[k];
               for (int i = 0; i < DIM; i++) e.data[i*OWID +: OWID] = OWID'(m_acc[k][i]);
               if (k == 0) q0.push_back(e); else q1.push_back(e);
               for (int i = 0; i < DIM; i++) m_acc[k][i] = 0;
               m_ovf[k] = 0;
            end
         end
      end
      if (!iclear && iswap && ready) m_cnt++;
      if (drain) m_cnt--;
   endfunction

   task automatic cyc(input bit v, input logic [DIM*IWID-1:0] d, input bit c,
                      input bit sw, input bit r);
      ivalid = v; idata = d; iclear = c; iswap = sw; iready = r;
      @(posedge clk);
      model_step();
      #1;
   endtask

   // Monitor: flags every cycle, data/ovf at each output handshake.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (run && rst_n) begin
            for (int k = 0; k < 2; k++) begin
               chk(k == 0 ? "sat_oValid" : "wrap_oValid", 64'(ovalid[k]), 64'(m_cnt != 0));
               chk(k == 0 ? "sat_oSwapReady" : "wrap_oSwapReady", 64'(osr[k]), 64'(m_cnt < NBANK - 1));
               if (ovalid[k] && iready) begin
                  if ((k == 0 ? q0.size() : q1.size()) == 0) begin
                     chk("drain_without_expected_bank", 64'(0), 64'(1));
                  end else begin
                     e = (k == 0) ? q0.pop_front() : q1.pop_front();
                     chk(k == 0 ? "sat_oData" : "wrap_oData", 64'(odata[k]), 64'(e.data));
                     chk(k == 0 ? "sat_oOvf" : "wrap_oOvf", 64'(oovf[k]), 64'(e.ovf));
                  end
               end
            end
         end
      end
   end

   initial begin
      logic [DIM*IWID-1:0] d;
      logic [DIM*OWID-1:0] x;
      rst_n = 1'b0;
      ivalid = 0; iclear = 0; iswap = 0; iready = 0; idata = '0;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("reset_oValid", 64'(ovalid[k]), 64'(0));
         chk("reset_oData", 64'(odata[k]), 64'(0));
         chk("reset_oOvf", 64'(oovf[k]), 64'(0));
         chk("reset_oSwapReady", 64'(osr[k]), 64'(1));
      end
      rst_n = 1'b1;
      run   = 1;

      // Five adds of {1,0,1,1}, swap with the fifth.
      d = {2'd1, 2'd0, 2'd1, 2'd1};
      repeat (4) cyc(1, d, 0, 0, 0);
      cyc(1, d, 0, 1, 0);
      x = {4'd5, 4'd0, 4'd5, 4'd5};
      chk("t1_valid_after_swap", 64'(ovalid[0]), 64'(1));
      chk("t1_data", 64'(odata[0]), 64'(x));
      chk("t1_ovf", 64'(oovf[0]), 64'(0));
      cyc(0, '0, 0, 0, 1);

      // Twenty ones on channel 0: clamp to 15 vs wrap to 4, both overflow.
      d = {2'd0, 2'd0, 2'd0, 2'd1};
      repeat (19) cyc(1, d, 0, 0, 0);
      cyc(1, d, 0, 1, 0);
      chk("t2_sat_ch0", 64'(odata[0][0]), 64'(15));
      chk("t2_sat_ovf", 64'(oovf[0]), 64'(1));
      chk("t2_wrap_ch0", 64'(odata[1][0]), 64'(4));
      chk("t2_wrap_ovf", 64'(oovf[1]), 64'(1));
      cyc(0, '0, 0, 0, 1);

      // Fill the ring, refused swap, then in-order drain.
      cyc(1, 8'h1b, 0, 0, 0);
      cyc(1, 8'h21, 0, 1, 0);
      cyc(1, 8'h3c, 0, 1, 0);
      chk("t3_swap_ready_low", 64'(osr[0]), 64'(0));
      cyc(1, 8'h55, 0, 1, 0);
      cyc(1, 8'h12, 0, 0, 0);
      cyc(0, '0, 0, 0, 1);
      cyc(0, '0, 0, 0, 1);

      // Swap and drain together with one sealed bank.
      cyc(1, 8'h07, 0, 1, 0);
      cyc(1, 8'h30, 0, 1, 1);
      cyc(0, '0, 0, 0, 1);

      // Clear beats valid and swap.
      cyc(1, 8'hff, 0, 0, 0);
      cyc(1, 8'hff, 0, 0, 0);
      cyc(1, 8'hff, 0, 0, 0);
      cyc(1, 8'hff, 1, 1, 0);
      chk("t5_no_swap", 64'(ovalid[0]), 64'(0));
      cyc(1, 8'h55, 0, 1, 0);
      chk("t5_fresh_bank", 64'(odata[0]), 64'(16'h1111));
      cyc(0, '0, 0, 0, 1);

      // Asynchronous reset with two sealed banks.
      cyc(1, 8'h99, 0, 1, 0);
      cyc(1, 8'h66, 0, 1, 0);
      @(negedge clk);
      #2 rst_n = 1'b0;
      ivalid = 0; iswap = 0; iready = 0;
      model_clear();
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("async_rst_oValid", 64'(ovalid[k]), 64'(0));
         chk("async_rst_oData", 64'(odata[k]), 64'(0));
         chk("async_rst_oOvf", 64'(oovf[k]), 64'(0));
         chk("async_rst_oSwapReady", 64'(osr[k]), 64'(1));
      end
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Random traffic.
      for (int n = 0; n < 1500; n++) begin
         cyc(($urandom % 4) != 0, (DIM*IWID)'($urandom), ($urandom % 40) == 0,
             ($urandom % 6) == 0, ($urandom % 3) != 0);
      end
      repeat (4) cyc(0, '0, 0, 0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/buffer_multi_bank_array.md
# buffer_multi_bank_array

Multi-bank accumulating buffer: NBANK banks of DIM unsigned accumulators in a ring, one bank accumulating incoming unary/bitstream counts while completed banks wait to be drained through a valid/ready output port. It generalises the two-bank ping-pong accumulator to arbitrary depth, with handshaked swap/drain, optional saturation and per-bank overflow reporting. It sits between the unary compute array and downstream binary consumers (memory writeback, next layer).

## Interface
- DIM, 4, channel count
- IWID, 1, input width per channel (unsigned)
- OWID, 8, accumulator width per channel; OWID >= IWID
- NBANK, 2, bank count; NBANK >= 2
- SAT, 1, 1 = clamp at 2^OWID-1; 0 = wrap modulo 2^OWID
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- iValid  input  1  iData valid this cycle
- iData  input  IWID x DIM  per-channel increment
- iClear  input  1  zero the accumulating bank (discard current window)
- iSwap  input  1  seal the accumulating bank, move to next bank
- oSwapReady  output  1  a free bank exists; iSwap will be accepted
- oValid  output  1  a sealed bank is presented on oData
- iReady  input  1  consumer accepts oData
- oData  output  OWID x DIM  contents of oldest sealed bank
- oOvf  output  1  presented bank overflowed (saturated or wrapped) during its window

## Operation
- State: wr_ptr, rd_ptr (mod NBANK), full_cnt (0..NBANK-1), per-bank sticky ovf bit. Bank wr_ptr is always accumulating; banks rd_ptr..rd_ptr+full_cnt-1 are sealed.
- Accumulate: iValid & ~iClear -> acc[wr][i] <= acc[wr][i] + iData[i] for all i; result width OWID+1 internally; carry out sets ovf[wr]; SAT=1 clamps to all-ones, SAT=0 keeps low OWID bits.
- iClear: acc[wr][*] <= 0, ovf[wr] <= 0; overrides iValid and iSwap in same cycle (swap not accepted).
- oSwapReady = (full_cnt < NBANK-1), combinational from registers.
- Swap accepted when iSwap & oSwapReady & ~iClear: bank wr sealed including any same-cycle iValid add; wr_ptr++, full_cnt++.
- Swap not accepted: ignored, no state change beyond normal accumulation; sender must hold or retry.
- oValid = (full_cnt != 0); oData = acc[rd]; oOvf = ovf[rd].
- Drain when oValid & iReady: acc[rd] <= 0, ovf[rd] <= 0, rd_ptr++, full_cnt--. Freed banks are thus always zero when they become accumulating.
- Swap and drain same cycle: full_cnt unchanged, both pointers advance.
- oData/oOvf held stable while oValid & ~iReady.

## Timing
- Reset: all acc = 0, ovf = 0, wr_ptr = rd_ptr = 0, full_cnt = 0 -> oValid = 0, oData = 0, oOvf = 0, oSwapReady = 1.
- Accumulate latency 1: add visible in bank on next edge.
- Swap at edge T -> oValid = 1 from T (after edge) if bank was first sealed; no combinational path iSwap->oValid or iReady->oSwapReady.
- NBANK=2: at most one sealed bank; swap blocked until it drains (drain and swap may coincide).
- Reset mid-window or mid-drain discards all banks immediately.

## Structure
- Package buffer_pkg: saturating-add function parameterised by width, pointer-increment-with-wrap function.
- One sub-module acc_bank: DIM accumulators of OWID with clear, add-enable, SAT mode, sticky ovf; instantiated NBANK times; top holds pointers, count, output mux.

## Test plan
- Reset then DIM=4, IWID=1: iValid=1, iData={1,0,1,1} for 5 cycles, iSwap on 5th -> oValid next, oData={5,0,5,5}, oOvf=0.
- OWID=4, SAT=1: 20 ones on channel 0, swap -> oData[0]=15, oOvf=1; SAT=0 same stimulus -> oData[0]=4, oOvf=1.
- NBANK=3, iReady=0: two swaps accepted, oSwapReady=0, third iSwap ignored and accumulation continues; iReady=1 drains in order bank0 then bank1.
- NBANK=2: iSwap and iReady same cycle with one sealed bank -> full_cnt stays 1, new bank presented, freed bank starts from 0.
- iClear with iValid and iSwap after 3 accumulations -> bank zero, no swap, oValid stays 0.
- rst_n low with two sealed banks -> all outputs return to reset values asynchronously.
